// File: rtl/seg_pkg.sv
//------------------------------------------------------------------------------
// Package     : seg_pkg
// Description : Shared constants for the seven-segment scan display.
//               HEX_PAT is the active-low {g,f,e,d,c,b,a} pattern for 0..F.
//               SEG_BLANK turns every segment off. AN_OFF disables every
//               digit; the user slices it down to its own digit count.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package seg_pkg;

  // Entry 0 is the leftmost element because of the ascending [0:15] range.
  localparam logic [0:15][6:0] HEX_PAT = {
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [31:0] AN_OFF    = '1;

endpackage : seg_pkg

`default_nettype wire

// File: rtl/hex7seg.sv
//------------------------------------------------------------------------------
// Module      : hex7seg
// Description : Combinational hex-nibble to seven-segment decoder.
//               The output pattern is active-low.
// Ports       : nibble  in   4  value 0..F
//               seg     out  7  {g,f,e,d,c,b,a}, active-low
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_PAT[nibble];

endmodule : hex7seg

`default_nettype wire

// File: rtl/led_scan_display.sv
//------------------------------------------------------------------------------
// Module      : led_scan_display
// Description : Drives an 8-digit, time-multiplexed, common-anode
//               seven-segment display from the CPU LedData word. It also
//               drives three discrete in-service LEDs. The data word is
//               latched once per scan frame, on the wrap to digit 0, so
//               that one frame always shows a single consistent value.
// Ports       : clk   in   1       system clock (cpu domain)
//               rst   in   1       asynchronous reset, active-high
//               data  in   WIDTH   value to show; nibble 0 = rightmost digit
//               irw   in   3       interrupt-in-service flags
//               hold  in   1       1 = do not reload the snapshot on wrap
//               an    out  DIGITS  digit enables, active-low
//               seg   out  7       {g,f,e,d,c,b,a}, active-low
//               dp    out  1       decimal point, active-low
//               led   out  3       registered copy of irw, active-high
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module led_scan_display
  import seg_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000,
  parameter int BLANK_LZ = 0
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  data,
  input  logic [2:0]        irw,
  input  logic              hold,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [2:0]        led
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  // The three discrete flags also appear as decimal points on the
  // leftmost three digits.
  localparam int DP_FIRST = DIGITS - 3;

  logic [CNT_W-1:0]  prescaler;
  logic [IDX_W-1:0]  idx;
  logic [WIDTH-1:0]  snapshot;

  logic              tick;
  logic              at_last;
  logic [IDX_W-1:0]  idx_next;
  logic [WIDTH-1:0]  snap_next;
  logic [3:0]        nibble;
  logic [6:0]        pattern;
  logic [DIGITS-1:0] blank_mask;
  logic [DIGITS-1:0] nz_from;
  logic [DIGITS-1:0] an_next;
  logic              dp_next;

  assign tick     = (prescaler == CNT_MAX);
  assign at_last  = (idx == IDX_LAST);
  assign idx_next = at_last ? '0 : idx + 1'b1;

  // The snapshot is only committed on tick. Wrapping on that tick with
  // hold low is what reloads it.
  assign snap_next = (at_last && !hold) ? data : snapshot;

  // The outputs are computed from the post-edge index and snapshot, so
  // the new digit becomes visible on the same edge that selects it.
  assign nibble  = snap_next[{idx_next, 2'b00} +: 4];
  assign an_next = ~(DIGITS'(1) << idx_next);

  hex7seg u_hex7seg (
    .nibble (nibble),
    .seg    (pattern)
  );

  // nz_from[i] is set when any nibble from digit i up to the leftmost
  // digit is non-zero. When it is clear, digit i is a leading zero.
  for (genvar i = 0; i < DIGITS; i++) begin : g_blank
    assign nz_from[i] = |snap_next[WIDTH-1 : i*4];
    if (i == 0) begin : g_lsd
      assign blank_mask[i] = 1'b0;
    end else begin : g_upper
      assign blank_mask[i] = (BLANK_LZ != 0) && !nz_from[i];
    end
  end

  always_comb begin
    dp_next = 1'b1;
    if (int'(idx_next) >= DP_FIRST) begin
      dp_next = ~irw[2'(int'(idx_next) - DP_FIRST)];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      idx       <= IDX_LAST;
      snapshot  <= '0;
      an        <= AN_OFF[DIGITS-1:0];
      seg       <= SEG_BLANK;
      dp        <= 1'b1;
      led       <= 3'b000;
    end else begin
      led       <= irw;
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        idx      <= idx_next;
        snapshot <= snap_next;
        an       <= an_next;
        seg      <= blank_mask[idx_next] ? SEG_BLANK : pattern;
        dp       <= dp_next;
      end
    end
  end

endmodule : led_scan_display

`default_nettype wire

// File: tb/tb_led_scan_display.sv
//------------------------------------------------------------------------------
// Module      : tb_led_scan_display
// Description : Scoreboard bench for led_scan_display. Two instances share
//               the stimulus, one without and one with leading-zero
//               blanking. A cycle-count reference model predicts each
//               digit refresh and queues it. A negedge monitor pops and
//               compares whenever a refresh is due, and otherwise expects
//               the outputs to hold.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_led_scan_display;

  localparam int SD = 4;
  localparam int ND = 8;
  localparam logic [6:0] HEX_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [15:0] RESET_W = {8'hFF, 7'h7F, 1'b1};

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic [31:0] data = 32'h0;
  logic [2:0]  irw  = 3'b000;
  logic        hold = 1'b0;

  logic [7:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1;
  logic [2:0]  led0, led1;

  int checks = 0;
  int passes = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [2:0]  exp_led = 3'b000;

  always #5 clk = ~clk;

  led_scan_display #(.WIDTH(32), .DIGITS(ND), .SCAN_DIV(SD), .BLANK_LZ(0)) dut0 (
    .clk(clk), .rst(rst), .data(data), .irw(irw), .hold(hold),
    .an(an0), .seg(seg0), .dp(dp0), .led(led0)
  );

  led_scan_display #(.WIDTH(32), .DIGITS(ND), .SCAN_DIV(SD), .BLANK_LZ(1)) dut1 (
    .clk(clk), .rst(rst), .data(data), .irw(irw), .hold(hold),
    .an(an1), .seg(seg1), .dp(dp1), .led(led1)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
  endtask

  // Expected {an, seg, dp} for digit d showing value s.
  function automatic logic [15:0] expect_word(input logic [31:0] s, input int d,
                                              input logic [2:0] ir, input bit blz);
    logic [6:0]  sg;
    logic [7:0]  a;
    logic        p;
    logic [31:0] upper;
    upper = s >> (4 * d);
    a = ~(8'h01 << d);
    if (blz && d > 0 && upper == 0) sg = 7'h7F;
    else sg = HEX_TAB[int'(upper & 32'hF)];
    p = !(d >= ND - 3 && ir[d - (ND - 3)] == 1'b1);
    return {a, sg, p};
  endfunction

  // Reference model: counts edges since reset release. Every SD-th edge
  // refreshes digit ((edges/SD)-1) mod ND. The frame value is reloaded
  // whenever that digit is 0 and hold is low.
  initial begin
    int cyc;
    int d;
    logic [31:0] msnap;
    cyc = 0;
    msnap = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        cyc = 0;
        msnap = 0;
        exp_led = 3'b000;
        q0.delete();
        q1.delete();
      end else begin
        exp_led = irw;
        cyc++;
        if (cyc % SD == 0) begin
          d = ((cyc / SD) - 1) % ND;
          if (d == 0 && !hold) msnap = data;
          q0.push_back(expect_word(msnap, d, irw, 1'b0));
          q1.push_back(expect_word(msnap, d, irw, 1'b1));
        end
      end
    end
  end

  // Monitor
  initial begin
    logic [15:0] last0, last1, e0, e1;
    last0 = RESET_W;
    last1 = RESET_W;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset_disp0", {16'h0, an0, seg0, dp0}, {16'h0, RESET_W});
        check("reset_disp1", {16'h0, an1, seg1, dp1}, {16'h0, RESET_W});
        check("reset_led", {26'h0, led0, led1}, 32'h0);
        last0 = RESET_W;
        last1 = RESET_W;
      end else begin
        e0 = (q0.size() != 0) ? q0.pop_front() : last0;
        e1 = (q1.size() != 0) ? q1.pop_front() : last1;
        check("scan_nolz", {16'h0, an0, seg0, dp0}, {16'h0, e0});
        check("scan_lz",   {16'h0, an1, seg1, dp1}, {16'h0, e1});
        check("led", {26'h0, led0, led1}, {26'h0, exp_led, exp_led});
        last0 = e0;
        last1 = e1;
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stimulus
  initial begin
    #1 rst = 1'b1;
    data = 32'h12345678;
    run(3);
    rst = 1'b0;

    // Basic scan; data changes while digit 3 is lit (edges 16..19).
    run(18);
    data = 32'hFFFF_FFFF;
    run(40);

    // Hold across a wrap, then release.
    hold = 1'b1;
    data = 32'hCAFE_BABE;
    run(40);
    hold = 1'b0;
    run(40);

    // Blanking patterns.
    data = 32'h0000_00A0;
    run(36);
    data = 32'h0;
    run(36);

    // Decimal point mapping.
    irw = 3'b101;
    run(36);

    // Asynchronous reset between edges, with new data for the restart.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst0", {16'h0, an0, seg0, dp0}, {16'h0, RESET_W});
    check("async_rst1", {16'h0, an1, seg1, dp1}, {16'h0, RESET_W});
    check("async_rst_led", {26'h0, led0, led1}, 32'h0);
    data = 32'h0BAD_F00D;
    run(2);
    rst = 1'b0;
    run(40);

    // Randomized frames.
    for (int f = 0; f < 30; f++) begin
      for (int c = 0; c < SD * ND; c++) begin
        irw = 3'($urandom);
        if ($urandom_range(0, 7) == 0) data = $urandom >> $urandom_range(0, 31);
        if (c == 0) hold = ($urandom_range(0, 3) == 0);
        run(1);
      end
    end
    hold = 1'b0;
    run(40);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_led_scan_display

`default_nettype wire

// File: doc/led_scan_display.md
Name: led_scan_display

Overview:
- Consumes the CPU's 32-bit LedData word (the ecall 0x22 output) and the 3-bit IRW in-service lamps.
- Drives an 8-digit, time-multiplexed, common-anode seven-segment display and three discrete LEDs.
- Sits directly downstream of cpu at board top level, in the same clock domain.
- Takes a per-frame snapshot of the data so each scan frame shows one consistent value.

Parameters:
- WIDTH, 32: width of data input; must equal DIGITS*4.
- DIGITS, 8: number of display digits.
- SCAN_DIV, 100000: clock cycles each digit stays lit; legal range is 1 or more.
- BLANK_LZ, 0: when 1, leading zero digits are blanked.

Ports:
- clk  input  1  system clock, same as cpu.
- rst  input  1  asynchronous active-high reset.
- data  input  WIDTH  value to display (cpu LedData). Nibble 0 is the rightmost digit.
- irw  input  3  interrupt-in-service flags (cpu IRW).
- hold  input  1  when 1, freezes the displayed value (snapshot is not reloaded).
- an  output  DIGITS  digit enables, active-low. an[0] is the rightmost digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- led  output  3  registered copy of irw, active-high.

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - prescaler=0, digit index idx=DIGITS-1, snapshot=0;
  - an=all 1s, seg=7'h7F, dp=1, led=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1, counter width $clog2(SCAN_DIV) with a minimum of 1.
  - tick=1 when the count is SCAN_DIV-1; the counter then wraps to 0.
  - SCAN_DIV=1 gives tick every cycle.
- On tick:
  - idx advances by 1 and wraps from DIGITS-1 to 0.
  - When the wrap to 0 happens and hold=0, the snapshot loads data on that same edge.
  - The first tick after reset always wraps, so the snapshot loads on the first tick when hold=0.
- Outputs are registered and update on the same edge as idx, using the new idx and new snapshot. Latency from tick to a visible change is 0 cycles after the edge.
  - an: only bit idx is 0.
  - seg: hex7seg(snapshot nibble idx), or 7'h7F when blanked.
  - dp: 0 only when idx is in {DIGITS-3..DIGITS-1} and irw[idx-(DIGITS-3)]=1, i.e. irw[2] maps to digit 7 and irw[0] to digit 5. irw is sampled on the tick edge.
- Between ticks, an, seg and dp hold their values.
- The first tick after reset drives digit 0. Before that tick the display is dark.
- Leading-zero blanking (BLANK_LZ=1): digit i>0 is blanked when snapshot nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked, so data=0 shows a single "0".
- led <= irw every cycle, with 1-cycle latency, independent of tick.
- A data change mid-frame is not shown until the next wrap to digit 0. hold=1 at the wrap edge suppresses that load only.
- A reset asserted mid-scan forces the reset values immediately, without waiting for a clock edge. Scanning restarts from the first tick after release.
- Segment patterns (active-low), 0..F:
  - 40 79 24 30 19 12 02 78
  - 00 10 08 03 46 21 06 0E

Decomposition:
- Package seg_pkg holds:
  - the 16-entry hex pattern constant table;
  - SEG_BLANK=7'h7F;
  - AN_OFF (all 1s).
- One combinational sub-module, hex7seg: 4-bit nibble in, 7-bit active-low pattern out.
- The prescaler, index counter, snapshot register, blanking logic and output registers stay in the top module.

Test Plan:
1. Basic scan. SCAN_DIV=4, BLANK_LZ=0, data=32'h12345678, hold=0, release reset at cycle 0.
   - Display is dark until the 4th rising edge.
   - Then an=FE, seg=00 ("8").
   - Every 4 cycles the next digit lights; an=7F shows seg=79 ("1").
   - After an=7F the scan wraps back to FE.
2. Frame consistency. Change data to 32'hFFFFFFFF while digit 3 is lit.
   - Digits 4..7 still show "4321".
   - After the wrap, every digit shows seg=0E.
3. Hold. With hold=1 across the wrap, new data is ignored and the old value repeats. Drop hold and the value loads at the next wrap.
4. Blanking. BLANK_LZ=1, data=32'h000000A0:
   - digit 0 seg=40, digit 1 seg=08, digits 2..7 seg=7F.
   - data=0: digit 0 seg=40 and all others blank.
5. IRW mapping. irw=3'b101:
   - led=101 one cycle after the change;
   - dp=0 only while an=7F (digit 7) or an=DF (digit 5); dp=1 on all other digits.
6. Async reset. Assert rst mid-digit between edges:
   - an=FF, seg=7F, dp=1, led=0 immediately;
   - after release, digit 0 lights at the SCAN_DIV-th edge with the freshly loaded data.
